// File: rtl/regbank_pkg.sv
// Shared register-bank definitions: data width, register count, index width,
// writeback requester ids and the "is this a real write" helper.
package regbank_pkg;

  localparam int unsigned REG_DW    = 32;
  localparam int unsigned REG_NREG  = 16;
  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_e;

  // R0 is hard-wired and indices past the bank are dropped.
  function automatic logic reg_writable(logic [REG_IDX_W-1:0] rd, int unsigned nreg);
    return (rd != '0) && (32'(rd) < nreg);
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus bundle: two requester handshakes, register-bank write port,
// pending-claim input and source busy checks.
interface reg_wb_arbiter_if
  import regbank_pkg::*;
#(
  parameter int unsigned DW = REG_DW
) ();

  logic                 a_valid;
  logic                 a_ready;
  logic [REG_IDX_W-1:0] a_rd;
  logic [DW-1:0]        a_data;

  logic                 b_valid;
  logic                 b_ready;
  logic [REG_IDX_W-1:0] b_rd;
  logic [DW-1:0]        b_data;

  logic                 wr_en;
  logic [REG_IDX_W-1:0] wr_addr;
  logic [DW-1:0]        wr_data;

  logic                 claim_valid;
  logic [REG_IDX_W-1:0] claim_rd;
  logic [REG_IDX_W-1:0] chk_rs;
  logic [REG_IDX_W-1:0] chk_rt;
  logic                 rs_busy;
  logic                 rt_busy;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output claim_valid, claim_rd, chk_rs, chk_rt,
    input  a_ready, b_ready, wr_en, wr_addr, wr_data, rs_busy, rt_busy
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  claim_valid, claim_rd, chk_rs, chk_rt,
    output a_ready, b_ready, wr_en, wr_addr, wr_data, rs_busy, rt_busy
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write bitmap: one bit per architectural register, set by the issue
// stage claim, cleared by the registered write; set wins on a same-cycle hit.
// Two combinational read ports; R0 and out-of-range indices read as 0.
module reg_scoreboard
  import regbank_pkg::*;
#(
  parameter int unsigned NREG = REG_NREG
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] rd_idx_a,
  input  logic [REG_IDX_W-1:0] rd_idx_b,
  output logic                 busy_a,
  output logic                 busy_b
);

  logic [NREG-1:0] pending_q, pending_d;
  logic [NREG-1:0] set_hit, clr_hit, sel_a, sel_b;

  // Bit 0 is never tracked; indices >= NREG match no bit.
  assign set_hit[0] = 1'b0;
  assign clr_hit[0] = 1'b0;
  assign sel_a[0]   = 1'b0;
  assign sel_b[0]   = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_bit
    assign set_hit[i] = set_en && (32'(set_idx) == 32'(i));
    assign clr_hit[i] = clr_en && (32'(clr_idx) == 32'(i));
    assign sel_a[i]   = (32'(rd_idx_a) == 32'(i));
    assign sel_b[i]   = (32'(rd_idx_b) == 32'(i));
  end

  // Next bitmap: clear first, then set, so a same-cycle claim survives.
  always_comb begin
    pending_d = (pending_q & ~clr_hit) | set_hit;
  end

  // Bitmap state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Read ports see only registered state; same-cycle claims appear next cycle.
  always_comb begin
    busy_a = |(pending_q & sel_a);
    busy_b = |(pending_q & sel_b);
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin writeback arbiter between the ALU (A) and load (B) paths with a
// registered register-bank write port. Optional pending-write scoreboard is
// built only when REG_WB_SCOREBOARD_EN is defined; otherwise busy outputs are 0.
module reg_wb_arbiter
  import regbank_pkg::*;
#(
  parameter int unsigned DW   = REG_DW,
  parameter int unsigned NREG = REG_NREG
) (
  input  logic             clk,
  input  logic             reset,
  reg_wb_arbiter_if.slave  bus
);

  req_id_e              last_q;
  logic                 grant_a, grant_b;
  logic                 win_valid;
  req_id_e              win_id;
  logic [REG_IDX_W-1:0] win_rd;
  logic [DW-1:0]        win_data;

  logic                 wr_en_q;
  logic [REG_IDX_W-1:0] wr_addr_q;
  logic [DW-1:0]        wr_data_q;

  // Grant: lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (bus.a_valid && bus.b_valid) begin
        grant_a = (last_q == REQ_LOAD);
        grant_b = (last_q == REQ_ALU);
      end else begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid;
      end
    end
  end

  // Winner mux feeding the write register.
  always_comb begin
    win_valid = grant_a || grant_b;
    win_id    = grant_b ? REQ_LOAD : REQ_ALU;
    win_rd    = grant_b ? bus.b_rd : bus.a_rd;
    win_data  = grant_b ? bus.b_data : bus.a_data;
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  // Last-grant pointer and write-port register; dropped writes keep addr/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q    <= REQ_LOAD;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (win_valid) begin
        last_q <= win_id;
        if (reg_writable(win_rd, NREG)) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= win_rd;
          wr_data_q <= win_data;
        end
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

`ifdef REG_WB_SCOREBOARD_EN
  reg_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (bus.claim_valid),
    .set_idx  (bus.claim_rd),
    .clr_en   (wr_en_q),
    .clr_idx  (wr_addr_q),
    .rd_idx_a (bus.chk_rs),
    .rd_idx_b (bus.chk_rt),
    .busy_a   (bus.rs_busy),
    .busy_b   (bus.rt_busy)
  );
`else
  logic unused_claim;
  assign unused_claim = ^{bus.claim_valid, bus.claim_rd, bus.chk_rs, bus.chk_rt};
  assign bus.rs_busy  = 1'b0;
  assign bus.rt_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed vectors with literal expectations plus a
// cycle-by-cycle reference model compared on every falling edge.
module tb_reg_wb_arbiter;

  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 16;
`ifdef REG_WB_SCOREBOARD_EN
  localparam logic SbEn = 1'b1;
`else
  localparam logic SbEn = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic chk_on;

  reg_wb_arbiter_if #(.DW(DW)) bus ();

  reg_wb_arbiter #(
    .DW   (DW),
    .NREG (NREG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic writable(logic [4:0] rd);
    return (rd != 5'd0) && (int'(rd) < int'(NREG));
  endfunction

  // Reference model: ready from valids + who went last; writes queued one cycle.
  logic        m_last_b;
  logic        m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  bit   [31:0] m_pending;
  logic        ea, eb, ers, ert;

  always @(negedge clk) begin
    ea  = !reset && bus.a_valid && (!bus.b_valid || m_last_b);
    eb  = !reset && bus.b_valid && (!bus.a_valid || !m_last_b);
    ers = SbEn && writable(bus.chk_rs) && m_pending[bus.chk_rs];
    ert = SbEn && writable(bus.chk_rt) && m_pending[bus.chk_rt];
    if (chk_on) begin
      check("model a_ready", 32'(bus.a_ready), 32'(ea));
      check("model b_ready", 32'(bus.b_ready), 32'(eb));
      check("model wr_en", 32'(bus.wr_en), 32'(m_wr_en));
      if (m_wr_en) begin
        check("model wr_addr", 32'(bus.wr_addr), 32'(m_wr_addr));
        check("model wr_data", bus.wr_data, m_wr_data);
      end
      check("model rs_busy", 32'(bus.rs_busy), 32'(ers));
      check("model rt_busy", 32'(bus.rt_busy), 32'(ert));
    end
    if (reset) begin
      m_last_b  = 1'b1;
      m_wr_en   = 1'b0;
      m_pending = '0;
    end else begin
      if (m_wr_en) m_pending[m_wr_addr] = 1'b0;
      if (bus.claim_valid && writable(bus.claim_rd)) m_pending[bus.claim_rd] = 1'b1;
      if (ea) begin
        m_last_b = 1'b0;
        m_wr_en  = writable(bus.a_rd);
        if (m_wr_en) begin
          m_wr_addr = bus.a_rd;
          m_wr_data = bus.a_data;
        end
      end else if (eb) begin
        m_last_b = 1'b1;
        m_wr_en  = writable(bus.b_rd);
        if (m_wr_en) begin
          m_wr_addr = bus.b_rd;
          m_wr_data = bus.b_data;
        end
      end else begin
        m_wr_en = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic        exp_a [4];
  logic [31:0] exp_d [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_on   = 1'b0;
    reset    = 1'b1;
    bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
    bus.claim_valid = 1'b0; bus.claim_rd = '0;
    bus.chk_rs = '0; bus.chk_rt = '0;
    step();
    step();
    chk_on = 1'b1;

    // Reset state
    check("reset wr_en", 32'(bus.wr_en), 32'd0);
    check("reset wr_addr", 32'(bus.wr_addr), 32'd0);
    check("reset wr_data", bus.wr_data, 32'd0);
    bus.a_valid = 1'b1;
    #1 check("reset a_ready", 32'(bus.a_ready), 32'd0);
    bus.a_valid = 1'b0;
    reset = 1'b0;
    step();

    // Lone ALU writeback
    bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h11;
    #1 check("lone a_ready", 32'(bus.a_ready), 32'd1);
    check("lone b_ready", 32'(bus.b_ready), 32'd0);
    step();
    bus.a_valid = 1'b0;
    check("lone wr_en", 32'(bus.wr_en), 32'd1);
    check("lone wr_addr", 32'(bus.wr_addr), 32'd3);
    check("lone wr_data", bus.wr_data, 32'h11);
    step();
    check("lone wr_en pulse", 32'(bus.wr_en), 32'd0);

    // Writes to R0 and past the bank are accepted but dropped
    bus.b_valid = 1'b1; bus.b_rd = 5'd0; bus.b_data = 32'hFFFF;
    #1 check("r0 b_ready", 32'(bus.b_ready), 32'd1);
    step();
    bus.b_rd = 5'd20;
    check("r0 wr_en", 32'(bus.wr_en), 32'd0);
    step();
    bus.b_valid = 1'b0;
    check("oob wr_en", 32'(bus.wr_en), 32'd0);
    step();

    // Claim / busy / clear, then same-cycle claim+clear
    bus.claim_valid = 1'b1; bus.claim_rd = 5'd5; bus.chk_rs = 5'd5; bus.chk_rt = 5'd5;
    #1 check("claim same-cycle rs_busy", 32'(bus.rs_busy), 32'd0);
    step();
    bus.claim_valid = 1'b0;
    check("claim rs_busy", 32'(bus.rs_busy), 32'(SbEn));
    bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'h55;
    step();
    bus.a_valid = 1'b0;
    check("wb5 wr_en", 32'(bus.wr_en), 32'd1);
    check("wb5 busy during write", 32'(bus.rs_busy), 32'(SbEn));
    step();
    check("wb5 cleared", 32'(bus.rs_busy), 32'd0);
    bus.claim_valid = 1'b1;
    step();
    bus.claim_valid = 1'b0;
    check("reclaim rs_busy", 32'(bus.rs_busy), 32'(SbEn));
    bus.a_valid = 1'b1; bus.a_data = 32'h56;
    step();
    bus.a_valid = 1'b0;
    bus.claim_valid = 1'b1;
    check("clash wr_en", 32'(bus.wr_en), 32'd1);
    step();
    bus.claim_valid = 1'b0;
    check("clash rs_busy", 32'(bus.rs_busy), 32'(SbEn));
    check("clash rt_busy", 32'(bus.rt_busy), 32'(SbEn));
    step();
    check("clash held", 32'(bus.rs_busy), 32'(SbEn));

    // Claim R7, check on the rt port
    bus.claim_valid = 1'b1; bus.claim_rd = 5'd7;
    step();
    bus.claim_valid = 1'b0;
    bus.chk_rt = 5'd7;
    #1 check("r7 rt_busy", 32'(bus.rt_busy), 32'(SbEn));
    step();

    // Reset while a request is pending
    bus.a_valid = 1'b1; bus.a_rd = 5'd4; bus.a_data = 32'h44;
    reset = 1'b1;
    #1 check("rst a_ready", 32'(bus.a_ready), 32'd0);
    step();
    reset = 1'b0;
    bus.a_valid = 1'b0;
    check("rst wr_en", 32'(bus.wr_en), 32'd0);
    for (int r = 0; r < 16; r++) begin
      bus.chk_rs = 5'(r);
      bus.chk_rt = 5'(r);
      #1;
      check("rst rs_busy", 32'(bus.rs_busy), 32'd0);
      check("rst rt_busy", 32'(bus.rt_busy), 32'd0);
    end
    step();

    // Tie after reset: A, B, A, B
    exp_a[0] = 1'b1; exp_a[1] = 1'b0; exp_a[2] = 1'b1; exp_a[3] = 1'b0;
    exp_d[0] = 32'hA0; exp_d[1] = 32'hB1; exp_d[2] = 32'hA2; exp_d[3] = 32'hB3;
    for (int k = 0; k < 4; k++) begin
      bus.a_valid = 1'b1; bus.a_rd = 5'd1; bus.a_data = 32'hA0 + 32'(k);
      bus.b_valid = 1'b1; bus.b_rd = 5'd2; bus.b_data = 32'hB0 + 32'(k);
      #1;
      check("tie a_ready", 32'(bus.a_ready), 32'(exp_a[k]));
      check("tie b_ready", 32'(bus.b_ready), 32'(!exp_a[k]));
      step();
      check("tie wr_en", 32'(bus.wr_en), 32'd1);
      check("tie wr_data", bus.wr_data, exp_d[k]);
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    step();

    // Mixed traffic checked by the model
    for (int i = 0; i < 24; i++) begin
      bus.a_valid     = (i % 3) != 0;
      bus.b_valid     = (i % 4) != 1;
      bus.a_rd        = 5'(i % 18);
      bus.b_rd        = 5'((i + 7) % 20);
      bus.a_data      = 32'h1000 + 32'(i);
      bus.b_data      = 32'h2000 + 32'(i);
      bus.claim_valid = (i % 2) != 0;
      bus.claim_rd    = 5'((i * 5) % 17);
      bus.chk_rs      = 5'(i % 16);
      bus.chk_rt      = 5'((i * 3) % 20);
      step();
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.claim_valid = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
